// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: walks rounds 0..NR, fetches one round key per
// round over a req/ack handshake, and holds the finished block until it is taken.
module aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       enc,
    input  logic       abort,
    output logic       ready,
    output logic       load_state,
    output logic       dp_enc,
    output logic       key_req,
    output logic [3:0] key_idx,
    input  logic       key_ack,
    output logic       state_en,
    output logic       first_round,
    output logic       last_round,
    output logic [3:0] round_idx,
    output logic       out_valid,
    input  logic       out_ready
);

    generate
        if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
            $error("aes_round_ctrl: NR must be 10, 12 or 14");
        end
    endgenerate

    localparam logic [3:0] NR_L = 4'(NR);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] r_q, r_d;
    logic       dp_enc_q, dp_enc_d;
    logic       ready_q, ready_d;
    logic       key_req_q, key_req_d;
    logic [3:0] key_idx_q, key_idx_d;
    logic       first_round_q, first_round_d;
    logic       last_round_q, last_round_d;
    logic [3:0] round_idx_q, round_idx_d;
    logic       out_valid_q, out_valid_d;

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        dp_enc_d = dp_enc_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = ROUND;
                    r_d      = 4'd0;
                    dp_enc_d = enc;
                end
            end
            ROUND: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (key_ack) begin
                    if (r_q == NR_L) state_d = DONE;
                    else             r_d     = r_q + 4'd1;
                end
            end
            DONE: begin
                if (abort || out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // NOTE: outputs are decoded from the *next* state and registered, so they
        // change on the same edge as the state itself with no combinational path.
        ready_d       = (state_d == IDLE);
        key_req_d     = (state_d == ROUND);
        out_valid_d   = (state_d == DONE);
        first_round_d = (state_d == ROUND) && (r_d == 4'd0);
        last_round_d  = (state_d == ROUND) && (r_d == NR_L);
        key_idx_d     = 4'd0;
        round_idx_d   = 4'd0;
        if (state_d == ROUND) begin
            key_idx_d   = dp_enc_d ? r_d : (NR_L - r_d);
            round_idx_d = r_d;
        end else if (state_d == DONE) begin
            round_idx_d = NR_L;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            r_q           <= 4'd0;
            dp_enc_q      <= 1'b0;
            ready_q       <= 1'b1;
            key_req_q     <= 1'b0;
            key_idx_q     <= 4'd0;
            first_round_q <= 1'b0;
            last_round_q  <= 1'b0;
            round_idx_q   <= 4'd0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            r_q           <= r_d;
            dp_enc_q      <= dp_enc_d;
            ready_q       <= ready_d;
            key_req_q     <= key_req_d;
            key_idx_q     <= key_idx_d;
            first_round_q <= first_round_d;
            last_round_q  <= last_round_d;
            round_idx_q   <= round_idx_d;
            out_valid_q   <= out_valid_d;
        end
    end

    // ready_q is already 1 during reset, so the load strobe is masked explicitly.
    assign load_state  = start & ready_q & ~rst;
    assign state_en    = key_req_q & key_ack & ~abort;

    assign ready       = ready_q;
    assign dp_enc      = dp_enc_q;
    assign key_req     = key_req_q;
    assign key_idx     = key_idx_q;
    assign first_round = first_round_q;
    assign last_round  = last_round_q;
    assign round_idx   = round_idx_q;
    assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: NR=10 and NR=14 instances driven by scripted and
// random blocks, with an AES-128 datapath model steered by the controller outputs.
module tb_aes_round_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, enc = 1'b0, abort = 1'b0, key_ack = 1'b0, out_ready = 1'b0;
    logic sel14 = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       ready10, load10, dp10, kreq10, se10, fr10, lr10, ov10;
    logic [3:0] kidx10, ridx10;
    logic       ready14, load14, dp14, kreq14, se14, fr14, lr14, ov14;
    logic [3:0] kidx14, ridx14;
    logic       start10, start14;

    assign start10 = start & ~sel14;
    assign start14 = start & sel14;

    aes_round_ctrl #(.NR(10)) dut10 (
        .clk(clk), .rst(rst), .start(start10), .enc(enc), .abort(abort),
        .ready(ready10), .load_state(load10), .dp_enc(dp10), .key_req(kreq10),
        .key_idx(kidx10), .key_ack(key_ack), .state_en(se10), .first_round(fr10),
        .last_round(lr10), .round_idx(ridx10), .out_valid(ov10), .out_ready(out_ready)
    );

    aes_round_ctrl #(.NR(14)) dut14 (
        .clk(clk), .rst(rst), .start(start14), .enc(enc), .abort(abort),
        .ready(ready14), .load_state(load14), .dp_enc(dp14), .key_req(kreq14),
        .key_idx(kidx14), .key_ack(key_ack), .state_en(se14), .first_round(fr14),
        .last_round(lr14), .round_idx(ridx14), .out_valid(ov14), .out_ready(out_ready)
    );

    // Layout: ready load dp_enc key_req key_idx[4] state_en first last round_idx[4] out_valid
    logic [15:0] snap10, snap14, snap;
    assign snap10 = {ready10, load10, dp10, kreq10, kidx10, se10, fr10, lr10, ridx10, ov10};
    assign snap14 = {ready14, load14, dp14, kreq14, kidx14, se14, fr14, lr14, ridx14, ov14};
    assign snap   = sel14 ? snap14 : snap10;

    localparam logic [15:0] IDLE_MASK = 16'hF0E1;
    localparam logic [15:0] DONE_MASK = 16'hF0FF;

    bit dp_hist [2];

    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] rk    [15];

    function automatic logic [15:0] pack(input logic rdy, input logic ld, input logic de,
                                         input logic kr, input logic [3:0] ki, input logic se,
                                         input logic fr, input logic lr, input logic [3:0] ri,
                                         input logic ov);
        return {rdy, ld, de, kr, ki, se, fr, lr, ri, ov};
    endfunction

    // ---------------- AES-128 reference arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b};
        return t[15-n -: 8];
    endfunction

    task automatic build_tables();
        logic [7:0] inv, s;
        for (int i = 0; i < 256; i++) begin
            inv = 8'h00;
            for (int k = 1; k < 256; k++)
                if (gmul(8'(i), 8'(k)) == 8'h01) inv = 8'(k);
            s = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
            sbox[i]  = s;
            isbox[s] = 8'(i);
        end
    endtask

    // AES-128 schedule, continued to 15 round keys so NR=14 blocks round-trip too.
    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 60; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int j = 0; j < 15; j++) rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    endtask

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        for (int n = 0; n < 16; n++)
            o[127-8*n -: 8] = inv ? isbox[s[127-8*n -: 8]] : sbox[s[127-8*n -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int src;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                src = inv ? (c - r + 4) % 4 : (c + r) % 4;
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*src) -: 8];
            end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0]   m [4];
        logic [7:0]   a [4];
        logic [7:0]   b;
        if (inv) begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
        else     begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127-8*(4*c+k) -: 8];
            for (int i = 0; i < 4; i++) begin
                b = 8'h00;
                for (int k = 0; k < 4; k++) b = b ^ gmul(m[(k - i + 4) % 4], a[k]);
                o[127-8*(4*c+i) -: 8] = b;
            end
        end
        return o;
    endfunction

    // One round of the shared datapath, steered only by the controller's outputs.
    function automatic logic [127:0] apply_round(input logic [127:0] s, input logic de,
                                                 input logic fr, input logic lr,
                                                 input logic [3:0] ki);
        logic [127:0] t;
        t = s;
        if (!fr) begin
            if (de) begin
                t = shift_rows(sub_bytes(t, 1'b0), 1'b0);
                if (!lr) t = mix_columns(t, 1'b0);
            end else begin
                t = sub_bytes(shift_rows(t, 1'b1), 1'b1);
            end
        end
        t = t ^ rk[ki];
        if (!de && !fr && !lr) t = mix_columns(t, 1'b1);
        return t;
    endfunction

    // ---------------- block driver with per-cycle expectations ----------------
    // abort_r in 0..nr aborts in that round on the ack cycle; abort_r == nr+1 aborts in DONE.
    task automatic run_block(input logic e, input logic [127:0] din, input int dmin,
                             input int dmax, input int hold, input int abort_r,
                             input bit spam, output logic [127:0] dout, output bit aborted);
        int           nr, c0, n_rc, se_cnt, d;
        bit           ab, ab_done;
        logic [15:0]  exp_v;
        logic [127:0] st;
        nr      = sel14 ? 14 : 10;
        ab_done = (abort_r == nr + 1);
        aborted = 1'b0;
        n_rc    = 0;
        se_cnt  = 0;
        st      = 'x;

        @(negedge clk);
        start = 1'b1; enc = e; key_ack = 1'b0; abort = 1'b0; out_ready = 1'b0;
        #1;
        exp_v = pack(1'b1, 1'b1, dp_hist[sel14], 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        checks++;
        if ((snap & IDLE_MASK) !== (exp_v & IDLE_MASK)) begin
            errors++;
            $display("FAIL accept nr=%0d: got %b want %b (mask %b)", nr, snap, exp_v, IDLE_MASK);
        end
        if (snap[14]) st = din;
        dp_hist[sel14] = e;
        c0 = cyc;

        for (int j = 0; j <= nr && !aborted; j++) begin
            d = $urandom_range(dmax, dmin);
            for (int w = 0; w <= d && !aborted; w++) begin
                @(negedge clk);
                start   = spam ? 1'($urandom_range(1, 0)) : 1'b0;
                enc     = 1'($urandom_range(1, 0));
                ab      = (j == abort_r) && (w == d);
                key_ack = (w == d);
                abort   = ab;
                #1;
                exp_v = pack(1'b0, 1'b0, e, 1'b1, e ? 4'(j) : 4'(nr - j), (w == d) && !ab,
                             j == 0, j == nr, 4'(j), 1'b0);
                checks++;
                if (snap !== exp_v) begin
                    errors++;
                    $display("FAIL round nr=%0d r=%0d wait=%0d: got %b want %b", nr, j, w, snap, exp_v);
                end
                if (snap[7]) begin
                    st = apply_round(st, snap[13], snap[6], snap[5], snap[11:8]);
                    se_cnt++;
                end
                n_rc++;
                aborted = ab;
            end
        end

        if (!aborted) begin
            checks++;
            if (se_cnt !== nr + 1) begin
                errors++;
                $display("FAIL state_en count nr=%0d: got %0d want %0d", nr, se_cnt, nr + 1);
            end
            for (int w = 0; w <= hold; w++) begin
                @(negedge clk);
                start     = spam ? 1'($urandom_range(1, 0)) : 1'b0;
                enc       = 1'($urandom_range(1, 0));
                key_ack   = 1'($urandom_range(1, 0));
                abort     = ab_done && (w == hold);
                out_ready = !ab_done && (w == hold);
                #1;
                if (w == 0) begin
                    checks++;
                    if (cyc - c0 !== n_rc + 1) begin
                        errors++;
                        $display("FAIL latency nr=%0d: got %0d want %0d", nr, cyc - c0, n_rc + 1);
                    end
                end
                exp_v = pack(1'b0, 1'b0, e, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'(nr), 1'b1);
                checks++;
                if ((snap & DONE_MASK) !== (exp_v & DONE_MASK)) begin
                    errors++;
                    $display("FAIL done hold nr=%0d w=%0d: got %b want %b", nr, w, snap, exp_v);
                end
            end
            aborted = ab_done;
        end

        @(negedge clk);
        start = 1'b0; key_ack = 1'b0; abort = 1'b0; out_ready = 1'b0;
        #1;
        exp_v = pack(1'b1, 1'b0, e, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        checks++;
        if ((snap & IDLE_MASK) !== (exp_v & IDLE_MASK)) begin
            errors++;
            $display("FAIL back to idle nr=%0d: got %b want %b", nr, snap, exp_v);
        end
        dout = st;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [15:0] rv;
        rv  = pack(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        rst = 1'b1; start = 1'b1; enc = 1'b1; key_ack = 1'b1; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (snap10 !== rv) begin
            errors++;
            $display("FAIL reset nr10: got %b want %b", snap10, rv);
        end
        checks++;
        if (snap14 !== rv) begin
            errors++;
            $display("FAIL reset nr14: got %b want %b", snap14, rv);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0; enc = 1'b0; key_ack = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ((snap10 & IDLE_MASK) !== (rv & IDLE_MASK)) begin
            errors++;
            $display("FAIL idle after reset: got %b want %b", snap10, rv);
        end
    endtask

    task automatic test_encrypt_ack_high();
        logic [127:0] res;
        bit ab;
        sel14 = 1'b0;
        run_block(1'b1, 128'h0, 0, 0, 0, -1, 1'b0, res, ab);
    endtask

    task automatic test_decrypt_slow_ack();
        logic [127:0] res;
        bit ab;
        sel14 = 1'b1;
        run_block(1'b0, {$urandom, $urandom, $urandom, $urandom}, 2, 2, 0, -1, 1'b0, res, ab);
        sel14 = 1'b0;
    endtask

    task automatic test_back_pressure();
        logic [127:0] res;
        bit ab;
        sel14 = 1'b0;
        run_block(1'b1, 128'h0, 0, 0, 7, -1, 1'b1, res, ab);
    endtask

    task automatic test_abort();
        logic [127:0] res;
        bit ab;
        sel14 = 1'b0;
        run_block(1'b1, 128'h0, 0, 0, 0, 4, 1'b0, res, ab);
        checks++;
        if (ab !== 1'b1) begin
            errors++;
            $display("FAIL abort flag: got %0d want 1", ab);
        end
        run_block(1'b0, 128'h0, 0, 1, 0, -1, 1'b0, res, ab);
        run_block(1'b1, 128'h0, 0, 0, 3, 11, 1'b0, res, ab);
        run_block(1'b1, 128'h0, 0, 0, 0, -1, 1'b0, res, ab);
    endtask

    task automatic test_reset_mid_round();
        logic [15:0]  rv;
        logic [127:0] res;
        bit ab;
        sel14 = 1'b0;
        rv = pack(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        start = 1'b1; enc = 1'b1; key_ack = 1'b1; abort = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        #1;
        checks++;
        if (ridx10 !== 4'd7) begin
            errors++;
            $display("FAIL pre-reset round: got %0d want 7", ridx10);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (snap10 !== rv) begin
            errors++;
            $display("FAIL async reset mid-round: got %b want %b", snap10, rv);
        end
        @(negedge clk);
        rst = 1'b0; key_ack = 1'b0;
        dp_hist[0] = 1'b0;
        run_block(1'b1, 128'h0, 0, 1, 0, -1, 1'b0, res, ab);
    endtask

    task automatic test_fips_vector();
        logic [127:0] pt, ct, back;
        bit ab;
        sel14 = 1'b0;
        pt = 128'h00112233445566778899aabbccddeeff;
        run_block(1'b1, pt, 0, 2, 1, -1, 1'b0, ct, ab);
        checks++;
        if (ct !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
            errors++;
            $display("FAIL fips encrypt: got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", ct);
        end
        run_block(1'b0, ct, 0, 2, 0, -1, 1'b0, back, ab);
        checks++;
        if (back !== pt) begin
            errors++;
            $display("FAIL fips decrypt: got %h want %h", back, pt);
        end
    endtask

    task automatic test_random();
        logic [127:0] pt, ct, back;
        bit ab, ab2;
        int nr, abort_r;
        for (int it = 0; it < 16; it++) begin
            sel14   = 1'($urandom_range(1, 0));
            nr      = sel14 ? 14 : 10;
            pt      = {$urandom, $urandom, $urandom, $urandom};
            abort_r = ($urandom_range(4, 0) == 0) ? int'($urandom_range(nr + 1, 0)) : -1;
            run_block(1'b1, pt, 0, 3, $urandom_range(3, 0), abort_r,
                      1'($urandom_range(1, 0)), ct, ab);
            if (!ab) begin
                run_block(1'b0, ct, 0, 3, $urandom_range(3, 0), -1,
                          1'($urandom_range(1, 0)), back, ab2);
                checks++;
                if (back !== pt) begin
                    errors++;
                    $display("FAIL random round-trip it=%0d nr=%0d: got %h want %h", it, nr, back, pt);
                end
            end
        end
        sel14 = 1'b0;
    endtask

    initial begin
        dp_hist[0] = 1'b0;
        dp_hist[1] = 1'b0;
        build_tables();
        expand_key(128'h000102030405060708090a0b0c0d0e0f);
        test_reset();
        test_encrypt_ack_high();
        test_decrypt_slow_ack();
        test_back_pressure();
        test_abort();
        test_reset_mid_round();
        test_fips_vector();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

endmodule
